// File: rtl/ex_stage_unit.sv
// Execute stage fed by the ID/EX buffer.
// Single-cycle ALU ops complete in one edge; MUL/DIV run an iterative
// 16-step shift-add / restoring shift-subtract loop while STALL holds ID/EX.
// Results and the WB/MEM control words are registered toward EX/MEM.
//
// Handshake: EXEC_VALID=1 with STALL=0 means the instruction is consumed at
// the next rising edge; STALL=1 means ID/EX must keep its contents. A
// completed op is presented for exactly one cycle with RESULT_VALID=1.
module ex_stage_unit #(
   parameter int WIDTH     = 16,
   parameter int FUNC_BITS = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EXEC_VALID,
   input  logic [WIDTH-1:0] FUNC_CODE,
   input  logic [WIDTH-1:0] VALUE1,
   input  logic [WIDTH-1:0] VALUE2,
   input  logic [WIDTH-1:0] DEST_ADDRESS,
   input  logic [WIDTH-1:0] WRITE_BACK,
   input  logic [WIDTH-1:0] MEMORY,
   output logic             STALL,
   output logic             BUSY,
   output logic             RESULT_VALID,
   output logic [WIDTH-1:0] RESULT_LO,
   output logic [WIDTH-1:0] RESULT_HI,
   output logic [WIDTH-1:0] DEST_ADDRESS_OUT,
   output logic [WIDTH-1:0] WRITE_BACK_OUT,
   output logic [WIDTH-1:0] MEMORY_OUT
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   localparam logic [FUNC_BITS-1:0] OP_ADD = FUNC_BITS'(0);
   localparam logic [FUNC_BITS-1:0] OP_SUB = FUNC_BITS'(1);
   localparam logic [FUNC_BITS-1:0] OP_AND = FUNC_BITS'(2);
   localparam logic [FUNC_BITS-1:0] OP_OR  = FUNC_BITS'(3);
   localparam logic [FUNC_BITS-1:0] OP_SLL = FUNC_BITS'(4);
   localparam logic [FUNC_BITS-1:0] OP_SRL = FUNC_BITS'(5);
   localparam logic [FUNC_BITS-1:0] OP_MUL = FUNC_BITS'(6);
   localparam logic [FUNC_BITS-1:0] OP_DIV = FUNC_BITS'(7);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [FUNC_BITS-1:0] opcode;
   logic                 is_multi;
   logic                 load_single;
   logic                 load_multi;
   logic                 finish;

   // Iterative engine state: a_q is the multiplicand or divisor,
   // lo_q the multiplier / dividend-quotient, hi_q the partial product / remainder.
   logic [CNT_W-1:0] count_q;
   logic             is_div_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] dest_q;
   logic [WIDTH-1:0] wb_q;
   logic [WIDTH-1:0] mem_q;

   logic [WIDTH-1:0] alu_lo;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   assign opcode   = FUNC_CODE[FUNC_BITS-1:0];
   assign is_multi = (opcode == OP_MUL) || (opcode == OP_DIV);

   // Single-cycle ALU result; opcodes 8-15 are NOPs that produce zero.
   always_comb begin
      alu_lo = '0;
      case (opcode)
         OP_ADD:  alu_lo = VALUE1 + VALUE2;
         OP_SUB:  alu_lo = VALUE1 - VALUE2;
         OP_AND:  alu_lo = VALUE1 & VALUE2;
         OP_OR:   alu_lo = VALUE1 | VALUE2;
         OP_SLL:  alu_lo = VALUE1 << VALUE2[3:0];
         OP_SRL:  alu_lo = VALUE1 >> VALUE2[3:0];
         default: alu_lo = '0;
      endcase
   end

   // One MUL shift-add or DIV restoring shift-subtract step from the engine state.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, a_q};
      step_hi   = mul_sum[WIDTH:1];
      step_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
      if (is_div_q) begin
         // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
         if (div_shift >= {1'b0, a_q}) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state, STALL and load/finish strobes.
   always_comb begin
      state_d     = state_q;
      STALL       = 1'b0;
      load_single = 1'b0;
      load_multi  = 1'b0;
      finish      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (EXEC_VALID) begin
               if (is_multi) begin
                  STALL      = 1'b1;
                  load_multi = 1'b1;
                  state_d    = ST_RUN;
               end else begin
                  load_single = 1'b1;
               end
            end
         end
         ST_RUN: begin
            // Released in the final step so ID/EX can load on the completing edge.
            STALL = (count_q != LAST_STEP);
            if (count_q == LAST_STEP) begin
               finish  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Engine registers, operand/tag latches and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q          <= '0;
         is_div_q         <= 1'b0;
         a_q              <= '0;
         hi_q             <= '0;
         lo_q             <= '0;
         dest_q           <= '0;
         wb_q             <= '0;
         mem_q            <= '0;
         BUSY             <= 1'b0;
         RESULT_VALID     <= 1'b0;
         RESULT_LO        <= '0;
         RESULT_HI        <= '0;
         DEST_ADDRESS_OUT <= '0;
         WRITE_BACK_OUT   <= '0;
         MEMORY_OUT       <= '0;
      end else begin
         BUSY         <= (state_d == ST_RUN);
         RESULT_VALID <= load_single | finish;
         if (load_multi) begin
            count_q  <= '0;
            is_div_q <= (opcode == OP_DIV);
            a_q      <= (opcode == OP_DIV) ? VALUE2 : VALUE1;
            lo_q     <= (opcode == OP_DIV) ? VALUE1 : VALUE2;
            hi_q     <= '0;
            dest_q   <= DEST_ADDRESS;
            wb_q     <= WRITE_BACK;
            mem_q    <= MEMORY;
         end else if (state_q == ST_RUN) begin
            count_q <= count_q + CNT_W'(1);
            hi_q    <= step_hi;
            lo_q    <= step_lo;
         end
         if (load_single) begin
            RESULT_LO        <= alu_lo;
            RESULT_HI        <= '0;
            DEST_ADDRESS_OUT <= DEST_ADDRESS;
            WRITE_BACK_OUT   <= WRITE_BACK;
            MEMORY_OUT       <= MEMORY;
         end else if (finish) begin
            RESULT_LO        <= step_lo;
            RESULT_HI        <= step_hi;
            DEST_ADDRESS_OUT <= dest_q;
            WRITE_BACK_OUT   <= wb_q;
            MEMORY_OUT       <= mem_q;
         end
      end
   end

endmodule
